fnd_scan_driver: RTL and testbench



---
 rtl/fnd_scan_driver_if.sv | 19 +
 rtl/fnd_scan_driver.sv | 116 +++++++++++
 tb/tb_fnd_scan_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_driver_if.sv
// Bus between the value source and fnd_scan_driver: a load handshake on the
// way in and the multiplexed digit code plus active-low commons on the way out.
interface fnd_scan_driver_if;
  logic [13:0] i_value;
  logic        i_load;
  logic        o_busy;
  logic [3:0]  o_fndData;
  logic [3:0]  o_fndCom;

  modport master (
    output i_value, i_load,
    input  o_busy, o_fndData, o_fndCom
  );

  modport slave (
    input  i_value, i_load,
    output o_busy, o_fndData, o_fndCom
  );
endinterface

// File: rtl/fnd_scan_driver.sv
// Binary-to-BCD (shift-add-3) converter feeding a 4-digit multiplexed display.
// Optional macro FND_LEADING_ZERO_BLANK_EN turns off leading-zero digits.
module fnd_scan_driver #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input logic          i_clk,
  input logic          i_reset,
  fnd_scan_driver_if.slave bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state, state_nxt;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [3:0]    step;
  logic [15:0]   disp;
  logic [3:0]    blank;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   bcd_adj;
  logic [29:0]   shifted;
  logic          last;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [13:0] sat(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  // Bit n set means digit n is a leading zero; the ones digit is never blanked.
  function automatic logic [3:0] blank_flags(input logic [15:0] d);
    logic [3:0] f;
    f = 4'b0000;
`ifdef FND_LEADING_ZERO_BLANK_EN
    f[3] = (d[15:12] == 4'd0);
    f[2] = f[3] && (d[11:8] == 4'd0);
    f[1] = f[2] && (d[7:4] == 4'd0);
`endif
    return f;
  endfunction

  assign last    = (step == 4'd13);
  assign bcd_adj = add3(bcd);
  assign shifted = {bcd_adj, bin} << 1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_load) state_nxt = CONV;
      CONV: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      step  <= '0;
      disp  <= '0;
      blank <= blank_flags(16'd0);
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.i_load) begin
            bin  <= sat(bus.i_value);
            bcd  <= '0;
            step <= '0;
          end
        end
        CONV: begin
          {bcd, bin} <= shifted;
          step       <= step + 4'd1;
          // Display is only touched with the finished result, never mid-conversion.
          if (last) begin
            disp  <= shifted[29:14];
            blank <= blank_flags(shifted[29:14]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Data and common both come from idx, so they switch on the same edge.
  assign bus.o_busy    = (state == CONV);
  assign bus.o_fndData = disp[{idx, 2'b00} +: 4];
  assign bus.o_fndCom  = blank[idx] ? 4'b1111 : ~(4'b0001 << idx);

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized bench for fnd_scan_driver against a decimal-arithmetic reference
// model of conversion timing, displayed value and scan slot.
module tb_fnd_scan_driver;
  localparam int CLK_HZ  = 8;
  localparam int SCAN_HZ = 2;
  localparam int DIV     = CLK_HZ / SCAN_HZ;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fnd_scan_driver_if bus();

  fnd_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges since reset, cycles of busy left, value in flight,
  // value on the display.
  int m_scan, m_left, m_pend, m_disp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_idx();
    return (m_scan / DIV) % 4;
  endfunction

  function automatic int exp_data();
    return (m_disp / p10(exp_idx())) % 10;
  endfunction

  function automatic int exp_com();
    int i, h;
    i = exp_idx();
    h = 0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    for (int d = 0; d < 4; d++)
      if ((m_disp / p10(d)) % 10 != 0) h = d;
    if (i > h) return 15;
`endif
    return (~(1 << i)) & 15;
  endfunction

  task automatic model_reset();
    m_scan = 0;
    m_left = 0;
    m_pend = 0;
    m_disp = 0;
  endtask

  task automatic model_step(input logic ld, input int v);
    m_scan++;
    if (m_left == 0) begin
      if (ld) begin
        m_pend = (v > 9999) ? 9999 : v;
        m_left = 14;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_disp = m_pend;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".busy"}, bus.o_busy, (m_left > 0));
    check({tag, ".data"}, bus.o_fndData, exp_data());
    check({tag, ".com"},  bus.o_fndCom,  exp_com());
  endtask

  // One clock: inputs present now are what the edge samples.
  task automatic cycle(input string tag);
    logic ld;
    int   v;
    ld = bus.i_load;
    v  = bus.i_value;
    @(posedge clk);
    #1;
    model_step(ld, v);
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic load_val(input int v, input string tag);
    bus.i_value = 14'(v);
    bus.i_load  = 1'b1;
    cycle(tag);
    bus.i_load  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".rst_busy"}, bus.o_busy, 0);
    check({tag, ".rst_com"},  bus.o_fndCom, 4'b1110);
    check({tag, ".rst_data"}, bus.o_fndData, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.i_value = '0;
    bus.i_load  = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset.busy", bus.o_busy, 0);
    check("reset.com",  bus.o_fndCom, 4'b1110);
    check("reset.data", bus.o_fndData, 0);
    rst = 1'b0;

    run(20, "idle");

    load_val(1234, "l1234");
    run(40, "v1234");

    load_val(12000, "lsat");
    run(32, "vsat");

    load_val(0, "lzero");
    run(32, "vzero");

    load_val(7, "lseven");
    run(32, "vseven");

    // Second strobe during conversion must be dropped.
    load_val(5678, "l5678");
    run(4, "c5678");
    load_val(42, "l42");
    run(40, "v5678");

    load_val(9999, "l9999");
    run(6, "c9999");
    do_reset("midrst");
    run(36, "postrst");

    // Held load: back-to-back conversions with a changing value.
    bus.i_load = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.i_value = 14'($urandom_range(0, 16383));
      cycle("held");
    end
    bus.i_load = 1'b0;
    run(20, "heldend");

    for (int i = 0; i < 500; i++) begin
      bus.i_load  = ($urandom_range(0, 9) == 0);
      bus.i_value = 14'($urandom_range(0, 16383));
      cycle("rand");
    end
    bus.i_load = 1'b0;
    run(20, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
